// File: rtl/btn_dir_conditioner.sv
// rtl/btn_dir_conditioner.sv - sync, debounce and one-hot arbitration of the four direction buttons
// Optional macro BTN_ACTIVE_LOW_EN: invert btn_raw ahead of the synchroniser for active-low buttons.
module btn_dir_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20,
    parameter int HOLD_CYCLES     = 5000000,
    parameter int HOLD_W          = 23
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    input  logic       gameover,
    output logic [3:0] btn,
    output logic       btn_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_HOLD
    } state_t;

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    logic [3:0]        w_raw;
    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [3:0]        r_stable;
    logic [3:0]        r_stable_d;
    logic [DB_W-1:0]   r_db_cnt [4];
    logic [3:0]        w_rise;
    logic              w_req_held;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_req;
    logic [3:0]        w_req_next;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_next;
    logic [3:0]        w_btn_next;

`ifdef BTN_ACTIVE_LOW_EN
    assign w_raw = ~btn_raw;
`else
    assign w_raw = btn_raw;
`endif

    // Fixed priority L > U > R > D when several press edges land together.
    function automatic logic [3:0] pick_one(input logic [3:0] m);
        if (m[3])      return 4'b1000;
        else if (m[2]) return 4'b0100;
        else if (m[1]) return 4'b0010;
        else if (m[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_stable[i] <= ~r_stable[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_rise     = r_stable & ~r_stable_d;
    assign w_req_held = |(r_req & r_stable);

    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_hold_next  = r_hold_cnt;
        if (gameover) begin
            w_state_next = S_IDLE;
            w_hold_next  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_hold_next = '0;
                    if (|w_rise) begin
                        w_state_next = S_PRESSED;
                        w_req_next   = pick_one(w_rise);
                    end
                end
                S_PRESSED: begin
                    if (|(w_rise & ~r_req)) begin
                        w_req_next = pick_one(w_rise & ~r_req);
                    end else if (!w_req_held) begin
                        w_state_next = S_HOLD;
                        w_hold_next  = '0;
                    end
                end
                S_HOLD: begin
                    if (|w_rise) begin
                        w_state_next = S_PRESSED;
                        w_req_next   = pick_one(w_rise);
                        w_hold_next  = '0;
                    end else if (r_hold_cnt == HOLD_MAX) begin
                        w_state_next = S_IDLE;
                        w_hold_next  = '0;
                    end else begin
                        w_hold_next = r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_hold_next  = '0;
                end
            endcase
        end
        w_btn_next = (w_state_next == S_IDLE) ? 4'b0000 : w_req_next;
    end

    // Output taken straight from flops so the movement block never sees a transient multi-hot value.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_req      <= '0;
            r_hold_cnt <= '0;
            btn        <= '0;
            btn_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_req      <= w_req_next;
            r_hold_cnt <= w_hold_next;
            btn        <= w_btn_next;
            btn_valid  <= |w_btn_next;
        end
    end

endmodule
